// File: rtl/kodd_hazard_mc_if.sv
// rtl/kodd_hazard_mc_if.sv - stage compare/control bundle between the kodd core and its hazard unit
interface kodd_hazard_mc_if #(
    parameter int NREAD = 2,
    parameter int REGW  = 4,
    parameter int CNTW  = 32
);
    logic [NREAD*REGW-1:0] RA_D;
    logic [NREAD*REGW-1:0] RA_E;
    logic [REGW-1:0]       WA_E;
    logic [REGW-1:0]       WA_M;
    logic [REGW-1:0]       WA_W;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic                  MemtoRegE;
    logic                  BranchTakenE;
    logic                  PCWrPendingF;
    logic                  PCSrcW;
    logic                  MulStartE;
    logic                  CntClr;

    logic [2*NREAD-1:0]    ForwardE;
    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  FlushD;
    logic                  FlushE;
    logic                  FlushM;
    logic                  MulBusy;
    logic [CNTW-1:0]       StallCnt;
    logic [CNTW-1:0]       FlushCnt;

    // master is the core side driving compares/control; slave is the hazard unit
    modport master (
        output RA_D, RA_E, WA_E, WA_M, WA_W, RegWriteM, RegWriteW, MemtoRegE,
               BranchTakenE, PCWrPendingF, PCSrcW, MulStartE, CntClr,
        input  ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               MulBusy, StallCnt, FlushCnt
    );
    modport slave (
        input  RA_D, RA_E, WA_E, WA_M, WA_W, RegWriteM, RegWriteW, MemtoRegE,
               BranchTakenE, PCWrPendingF, PCSrcW, MulStartE, CntClr,
        output ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               MulBusy, StallCnt, FlushCnt
    );
endinterface

// File: rtl/kodd_hazard_mc.sv
// rtl/kodd_hazard_mc.sv - NREAD-port hazard/forwarding unit with multi-cycle Execute sequencer and perf counters
module kodd_hazard_mc #(
    parameter int NREAD   = 2,
    parameter int REGW    = 4,
    parameter int MUL_LAT = 3,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               reset,
    kodd_hazard_mc_if.slave    hz
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int              CW        = $clog2(MUL_LAT) + 1;
    localparam bit              MULTI     = (MUL_LAT > 1);
    localparam logic [CW-1:0]   CNT_START = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [REGW-1:0] PC_IDX    = '1;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mul_stall;
    logic               ld_stall;
    logic [2*NREAD-1:0] fwd;
    logic [REGW-1:0]    ra_e;
    logic [CNTW-1:0]    stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MulStall covers the first MUL_LAT-1 Execute cycles; the last one releases the pipe
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MULTI && hz.MulStartE) begin
                    mul_stall = 1'b1;
                    cnt_d     = CNT_START;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mul_stall = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fwd  = '0;
        ra_e = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra_e = hz.RA_E[i*REGW +: REGW];
            if (ra_e != PC_IDX) begin
                if (hz.RegWriteM && (hz.WA_M == ra_e))
                    fwd[2*i +: 2] = 2'b10;
                else if (hz.RegWriteW && (hz.WA_W == ra_e))
                    fwd[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        ld_stall = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            if (hz.WA_E == hz.RA_D[i*REGW +: REGW])
                ld_stall = hz.MemtoRegE;
        end
        if (!hz.MemtoRegE)
            ld_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset || hz.CntClr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((ld_stall || mul_stall) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            if (hz.BranchTakenE && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNTW'(1);
        end
    end

    // a D register held by the sequencer must never be cleared underneath it
    assign hz.ForwardE = fwd;
    assign hz.StallF   = ld_stall | hz.PCWrPendingF | mul_stall;
    assign hz.StallD   = ld_stall | mul_stall;
    assign hz.StallE   = mul_stall;
    assign hz.FlushM   = mul_stall;
    assign hz.FlushE   = (ld_stall | hz.BranchTakenE) & ~mul_stall;
    assign hz.FlushD   = (hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE) & ~mul_stall;
    assign hz.MulBusy  = (state_q == BUSY);
    assign hz.StallCnt = stall_cnt_q;
    assign hz.FlushCnt = flush_cnt_q;
endmodule

// File: tb/tb_kodd_hazard_mc.sv
// tb/tb_kodd_hazard_mc.sv - directed bench for kodd_hazard_mc (MUL_LAT=3/CNTW=4 and MUL_LAT=1 instances)
module tb_kodd_hazard_mc;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    kodd_hazard_mc_if #(.NREAD(2), .REGW(4), .CNTW(4)) bus_a ();
    kodd_hazard_mc_if #(.NREAD(2), .REGW(4), .CNTW(4)) bus_b ();

    kodd_hazard_mc #(.NREAD(2), .REGW(4), .MUL_LAT(3), .CNTW(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (bus_a.slave)
    );

    kodd_hazard_mc #(.NREAD(2), .REGW(4), .MUL_LAT(1), .CNTW(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks follow 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus_a.RA_D = '0; bus_a.RA_E = '0; bus_a.WA_E = '0; bus_a.WA_M = '0; bus_a.WA_W = '0;
        bus_a.RegWriteM = 0; bus_a.RegWriteW = 0; bus_a.MemtoRegE = 0; bus_a.BranchTakenE = 0;
        bus_a.PCWrPendingF = 0; bus_a.PCSrcW = 0; bus_a.MulStartE = 0; bus_a.CntClr = 0;
        bus_b.RA_D = '0; bus_b.RA_E = '0; bus_b.WA_E = '0; bus_b.WA_M = '0; bus_b.WA_W = '0;
        bus_b.RegWriteM = 0; bus_b.RegWriteW = 0; bus_b.MemtoRegE = 0; bus_b.BranchTakenE = 0;
        bus_b.PCWrPendingF = 0; bus_b.PCSrcW = 0; bus_b.MulStartE = 0; bus_b.CntClr = 0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mulbusy", bus_a.MulBusy, 0);
        chk("rst_stallcnt", bus_a.StallCnt, 0);
        chk("rst_flushcnt", bus_a.FlushCnt, 0);
        chk("rst_stallf", bus_a.StallF, 0);

        // forwarding priority
        bus_a.RA_E = {4'd3, 4'd3}; bus_a.WA_M = 4'd3; bus_a.RegWriteM = 1;
        bus_a.WA_W = 4'd3; bus_a.RegWriteW = 1;
        #1 chk("fwd_m_beats_w", bus_a.ForwardE, 4'b1010);
        bus_a.RegWriteM = 0;
        #1 chk("fwd_w_only", bus_a.ForwardE, 4'b0101);
        bus_a.RA_E = {4'd15, 4'd15}; bus_a.WA_M = 4'd15; bus_a.WA_W = 4'd15; bus_a.RegWriteM = 1;
        #1 chk("fwd_pc_never", bus_a.ForwardE, 4'b0000);
        bus_a.RA_E = {4'd7, 4'd3}; bus_a.WA_M = 4'd7; bus_a.WA_W = 4'd3;
        #1 chk("fwd_mixed", bus_a.ForwardE, 4'b1001);
        bus_a.RegWriteM = 0; bus_a.RegWriteW = 0;

        // load-use on port 1
        bus_a.MemtoRegE = 1; bus_a.WA_E = 4'd5; bus_a.RA_D = {4'd5, 4'd0};
        #1;
        chk("ld_stallf", bus_a.StallF, 1);
        chk("ld_stalld", bus_a.StallD, 1);
        chk("ld_flushe", bus_a.FlushE, 1);
        chk("ld_stalle", bus_a.StallE, 0);
        chk("ld_flushd", bus_a.FlushD, 0);
        tick();
        bus_a.MemtoRegE = 0;
        #1 chk("ld_stallcnt", bus_a.StallCnt, 1);

        // multi-cycle op held for MUL_LAT=3 cycles, with a pending PC write mid-sequence
        bus_a.MulStartE = 1;
        #1;
        chk("mc1_stalle", bus_a.StallE, 1);
        chk("mc1_flushm", bus_a.FlushM, 1);
        chk("mc1_busy", bus_a.MulBusy, 0);
        tick();
        bus_a.PCWrPendingF = 1;
        #1;
        chk("mc2_stalle", bus_a.StallE, 1);
        chk("mc2_busy", bus_a.MulBusy, 1);
        chk("mc2_flushd_masked", bus_a.FlushD, 0);
        chk("mc2_stallf", bus_a.StallF, 1);
        tick();
        chk("mc3_stalle", bus_a.StallE, 0);
        chk("mc3_busy", bus_a.MulBusy, 1);
        chk("mc3_flushd", bus_a.FlushD, 1);
        chk("mc3_stallf", bus_a.StallF, 1);
        tick();
        bus_a.MulStartE = 0; bus_a.PCWrPendingF = 0;
        #1;
        chk("mc_idle", bus_a.MulBusy, 0);
        chk("mc_stallcnt", bus_a.StallCnt, 3);

        // MUL_LAT=1 never stalls
        bus_b.MulStartE = 1;
        #1 chk("lat1_stalle", bus_b.StallE, 0);
        tick();
        chk("lat1_busy", bus_b.MulBusy, 0);
        chk("lat1_stalle2", bus_b.StallE, 0);
        bus_b.MulStartE = 0;

        // reset during the first BUSY cycle aborts and re-arms
        bus_a.MulStartE = 1;
        tick();
        chk("rb_busy", bus_a.MulBusy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rb_after_busy", bus_a.MulBusy, 0);
        chk("rb_after_stallcnt", bus_a.StallCnt, 0);
        chk("rb_rearm_stalle", bus_a.StallE, 1);
        tick();
        bus_a.MulStartE = 0;
        #1 chk("rb_rearm_busy", bus_a.MulBusy, 1);
        tick();
        tick();
        chk("rb_done_busy", bus_a.MulBusy, 0);
        chk("rb_done_stallcnt", bus_a.StallCnt, 2);

        // FlushCnt saturation at 15, then clear with priority over increment
        bus_a.BranchTakenE = 1;
        #1;
        chk("br_flushe", bus_a.FlushE, 1);
        chk("br_flushd", bus_a.FlushD, 1);
        for (int i = 0; i < 16; i++) tick();
        chk("sat_flushcnt", bus_a.FlushCnt, 15);
        bus_a.CntClr = 1;
        tick();
        chk("clr_flushcnt", bus_a.FlushCnt, 0);
        chk("clr_stallcnt", bus_a.StallCnt, 0);
        bus_a.CntClr = 0;
        tick();
        chk("post_clr_flushcnt", bus_a.FlushCnt, 1);
        bus_a.BranchTakenE = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
